// File: rtl/phase_scheduler.sv
// rtl/phase_scheduler.sv - tick-driven two-road light sequencer with adaptive green and pedestrian walk
module phase_scheduler #(
  parameter int TICK_DIV  = 4,
  parameter int MIN_GREEN = 3,
  parameter int MAX_GREEN = 6,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pedButton,
  input  logic [2:0] mainTrafficIn,
  input  logic [2:0] sideTrafficIn,
  output logic       MG,
  output logic       MY,
  output logic       MR,
  output logic       SG,
  output logic       SY,
  output logic       SR,
  output logic       pedLight,
  output logic [2:0] phase
);

  localparam logic [2:0] MAIN_GREEN  = 3'd0;
  localparam logic [2:0] MAIN_YELLOW = 3'd1;
  localparam logic [2:0] ALL_RED     = 3'd2;
  localparam logic [2:0] SIDE_GREEN  = 3'd3;
  localparam logic [2:0] SIDE_YELLOW = 3'd4;
  localparam logic [2:0] PED_WALK    = 3'd5;

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  localparam logic [5:0] T_MIN  = 6'(MIN_GREEN - 1);
  localparam logic [5:0] T_MAX  = 6'(MAX_GREEN - 1);
  localparam logic [5:0] T_YEL  = 6'(YELLOW_T - 1);
  localparam logic [5:0] T_AR   = 6'(ALLRED_T - 1);
  localparam logic [5:0] T_WALK = 6'(WALK_T - 1);

  // lamp vector order: {MG, MY, MR, SG, SY, SR, pedLight}
  localparam logic [6:0] LAMPS_RESET = 7'b0010010;

  logic [PW-1:0] presc;
  logic          tick;
  logic [5:0]    timer;
  logic [2:0]    state;
  logic [2:0]    next_state;
  logic          last_dir;
  logic          ped_s1;
  logic          ped_s2;
  logic          ped_s3;
  logic          ped_rise;
  logic          ped_pending;
  logic          enter_walk;
  logic [6:0]    lamps;
  logic [6:0]    lamps_next;

  assign tick       = (presc == PRE_LAST);
  assign ped_rise   = ped_s2 & ~ped_s3;
  assign enter_walk = (next_state == PED_WALK) && (state != PED_WALK);

  always_comb begin
    next_state = state;
    case (state)
      MAIN_GREEN: begin
        if (tick && (((timer >= T_MIN) && ((sideTrafficIn > mainTrafficIn) || ped_pending)) ||
                     ((timer >= T_MAX) && ((sideTrafficIn != 3'd0) || ped_pending))))
          next_state = MAIN_YELLOW;
      end
      MAIN_YELLOW: begin
        if (tick && (timer == T_YEL)) next_state = ALL_RED;
      end
      ALL_RED: begin
        if (tick && (timer == T_AR)) begin
          if (ped_pending)   next_state = PED_WALK;
          else if (last_dir) next_state = MAIN_GREEN;
          else               next_state = SIDE_GREEN;
        end
      end
      SIDE_GREEN: begin
        if (tick && (((timer >= T_MIN) && ((sideTrafficIn <= mainTrafficIn) || ped_pending)) ||
                     (timer >= T_MAX)))
          next_state = SIDE_YELLOW;
      end
      SIDE_YELLOW: begin
        if (tick && (timer == T_YEL)) next_state = ALL_RED;
      end
      PED_WALK: begin
        if (tick && (timer == T_WALK)) next_state = last_dir ? MAIN_GREEN : SIDE_GREEN;
      end
      default: next_state = ALL_RED;
    endcase
  end

  // Lamps are decoded from the upcoming state so they land on the same edge as the state.
  always_comb begin
    lamps_next = LAMPS_RESET;
    case (next_state)
      MAIN_GREEN:  lamps_next = 7'b1000010;
      MAIN_YELLOW: lamps_next = 7'b0100010;
      ALL_RED:     lamps_next = 7'b0010010;
      SIDE_GREEN:  lamps_next = 7'b0011000;
      SIDE_YELLOW: lamps_next = 7'b0010100;
      PED_WALK:    lamps_next = 7'b0010011;
      default:     lamps_next = LAMPS_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc       <= '0;
      timer       <= '0;
      state       <= ALL_RED;
      last_dir    <= 1'b1;
      ped_s1      <= 1'b0;
      ped_s2      <= 1'b0;
      ped_s3      <= 1'b0;
      ped_pending <= 1'b0;
      lamps       <= LAMPS_RESET;
    end else begin
      presc  <= tick ? '0 : presc + PW'(1);
      ped_s1 <= pedButton;
      ped_s2 <= ped_s1;
      ped_s3 <= ped_s2;
      // A fresh press on the walk-entry edge must survive the clear.
      if (ped_rise)        ped_pending <= 1'b1;
      else if (enter_walk) ped_pending <= 1'b0;
      if (next_state != state) begin
        timer <= '0;
        if (next_state == ALL_RED) begin
          if (state == MAIN_YELLOW)      last_dir <= 1'b0;
          else if (state == SIDE_YELLOW) last_dir <= 1'b1;
        end
      end else if (tick && (timer != 6'd63)) begin
        timer <= timer + 6'd1;
      end
      state <= next_state;
      lamps <= lamps_next;
    end
  end

  assign {MG, MY, MR, SG, SY, SR, pedLight} = lamps;
  assign phase = state;

endmodule

// File: tb/tb_phase_scheduler.sv
// tb/tb_phase_scheduler.sv - directed and randomized checks of phase_scheduler against a tick-level model
module tb_phase_scheduler;
  localparam int TICK_DIV  = 4;
  localparam int MIN_GREEN = 3;
  localparam int MAX_GREEN = 6;
  localparam int YELLOW_T  = 2;
  localparam int ALLRED_T  = 1;
  localparam int WALK_T    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pedButton = 1'b0;
  logic [2:0] mainTrafficIn = 3'd0;
  logic [2:0] sideTrafficIn = 3'd0;
  logic       MG, MY, MR, SG, SY, SR, pedLight;
  logic [2:0] phase;

  phase_scheduler #(
    .TICK_DIV(TICK_DIV), .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
    .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .WALK_T(WALK_T)
  ) dut (
    .clk(clk), .reset(reset), .pedButton(pedButton),
    .mainTrafficIn(mainTrafficIn), .sideTrafficIn(sideTrafficIn),
    .MG(MG), .MY(MY), .MR(MR), .SG(SG), .SY(SY), .SR(SR),
    .pedLight(pedLight), .phase(phase)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: phase code, ticks spent in phase, direction and pending walk.
  int m_phase, m_t, edge_n;
  bit m_last, m_pend;
  bit h[3];
  bit rnd_ped = 0;
  int ped_at[3] = '{-100, -100, -100};
  int dir_edge[$];
  int dir_ph[$];

  function automatic logic [6:0] lamps_of(int p);
    case (p)
      0: return 7'b1000010;
      1: return 7'b0100010;
      2: return 7'b0010010;
      3: return 7'b0011000;
      4: return 7'b0010100;
      5: return 7'b0010011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 2; m_t = 0; edge_n = 0; m_last = 1; m_pend = 0;
    h[0] = 0; h[1] = 0; h[2] = 0;
  endtask

  task automatic model_step();
    int nxt;
    bit tick, rise;
    edge_n++;
    tick = (edge_n % TICK_DIV) == 0;
    rise = h[1] && !h[2];
    nxt = m_phase;
    if (tick) begin
      case (m_phase)
        0: if ((m_t >= MIN_GREEN - 1 && (sideTrafficIn > mainTrafficIn || m_pend)) ||
               (m_t >= MAX_GREEN - 1 && (sideTrafficIn != 0 || m_pend))) nxt = 1;
        1, 4: if (m_t == YELLOW_T - 1) nxt = 2;
        2: if (m_t == ALLRED_T - 1) nxt = m_pend ? 5 : (m_last ? 0 : 3);
        3: if ((m_t >= MIN_GREEN - 1 && (sideTrafficIn <= mainTrafficIn || m_pend)) ||
               m_t >= MAX_GREEN - 1) nxt = 4;
        5: if (m_t == WALK_T - 1) nxt = m_last ? 0 : 3;
        default: nxt = 2;
      endcase
    end
    if (rise) m_pend = 1;
    else if (nxt == 5 && m_phase != 5) m_pend = 0;
    if (nxt != m_phase) begin
      if (nxt == 2) m_last = (m_phase == 4);
      m_t = 0;
    end else if (tick && m_t < 63) begin
      m_t++;
    end
    m_phase = nxt;
    h[2] = h[1]; h[1] = h[0]; h[0] = pedButton;
  endtask

  task automatic run_cycles(int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check($sformatf("outputs@edge%0d", edge_n), 32'({MG, MY, MR, SG, SY, SR, pedLight, phase}),
            32'({lamps_of(m_phase), 3'(m_phase)}));
      if (dir_edge.size() > 0 && dir_edge[0] == edge_n) begin
        check($sformatf("phase_at_edge%0d", edge_n), 32'(phase), 32'(dir_ph[0]));
        void'(dir_edge.pop_front());
        void'(dir_ph.pop_front());
      end
      if (rnd_ped) begin
        if ($urandom_range(0, 29) == 0) pedButton = ~pedButton;
      end else begin
        pedButton = 1'b0;
        foreach (ped_at[i])
          if (edge_n >= ped_at[i] && edge_n < ped_at[i] + 2) pedButton = 1'b1;
      end
    end
  endtask

  task automatic expect_at(int e, int p);
    dir_edge.push_back(e);
    dir_ph.push_back(p);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pedButton = 1'b0;
    ped_at = '{-100, -100, -100};
    dir_edge.delete();
    dir_ph.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check("reset_lamps", 32'({MG, MY, MR, SG, SY, SR, pedLight}), 32'(7'b0010010));
    check("reset_phase", 32'(phase), 32'd2);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // no demand: rest in main green
    expect_at(3, 2); expect_at(4, 0); expect_at(200, 0);
    run_cycles(204);

    // side demand beats main
    do_reset();
    sideTrafficIn = 3'd3; mainTrafficIn = 3'd1;
    expect_at(15, 0); expect_at(16, 1); expect_at(24, 2); expect_at(28, 3);
    expect_at(52, 4); expect_at(60, 2); expect_at(64, 0);
    run_cycles(70);

    // main demand dominates: green runs to max
    do_reset();
    sideTrafficIn = 3'd1; mainTrafficIn = 3'd7;
    expect_at(27, 0); expect_at(28, 1); expect_at(36, 2); expect_at(40, 3); expect_at(52, 4);
    run_cycles(60);

    // single pedestrian press
    do_reset();
    sideTrafficIn = 3'd0; mainTrafficIn = 3'd0;
    ped_at = '{5, -100, -100};
    expect_at(16, 1); expect_at(24, 2); expect_at(28, 5); expect_at(44, 3); expect_at(56, 4);
    run_cycles(60);

    // press landing on walk entry plus one during walk
    do_reset();
    ped_at = '{5, 25, 34};
    expect_at(28, 5); expect_at(44, 3); expect_at(56, 4); expect_at(64, 2);
    expect_at(68, 5); expect_at(84, 0);
    run_cycles(90);

    // asynchronous reset during main yellow
    do_reset();
    sideTrafficIn = 3'd3; mainTrafficIn = 3'd1;
    expect_at(17, 1);
    run_cycles(17);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_lamps", 32'({MG, MY, MR, SG, SY, SR, pedLight}), 32'(7'b0010010));
    check("async_reset_phase", 32'(phase), 32'd2);
    sideTrafficIn = 3'd0; mainTrafficIn = 3'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    expect_at(3, 2); expect_at(4, 0); expect_at(100, 0);
    run_cycles(100);

    // randomized demand and button activity
    rnd_ped = 1;
    repeat (4) begin
      do_reset();
      repeat (8) begin
        mainTrafficIn = 3'($urandom_range(0, 7));
        sideTrafficIn = 3'($urandom_range(0, 7));
        run_cycles(48);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
